// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception responder: FSM states,
// CP0 register numbers, Status bit positions and exception codes.
package cp0_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_EXC_PEND,
      ST_HANDLER,
      ST_RET_PEND
   } cp0_state_t;

   localparam logic [4:0] CP0_REG_COUNT  = 5'd9;
   localparam logic [4:0] CP0_REG_STATUS = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_REG_EPC    = 5'd14;

   localparam int unsigned STATUS_IE_BIT  = 0;
   localparam int unsigned STATUS_EXL_BIT = 1;

   localparam logic [4:0] EXC_CODE_OV = 5'd12;

endpackage

// File: rtl/cp0_regs.sv
// CP0 register file: Count, Status, Cause, EPC with mtc0 write port and
// combinational mfc0 read mux. Exception-side updates take priority.
module cp0_regs
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic [4:0]  cp0_raddr,
   output logic [31:0] cp0_rdata,
   input  logic        epc_load,
   input  logic [31:0] epc_value,
   input  logic        exl_set,
   input  logic        exl_clr,
   input  logic        exccode_load,
   input  logic [4:0]  exccode_value,
   output logic [31:0] epc,
   output logic        exl
);

   logic [31:0] count;
   logic        ie;
   logic [4:0]  exccode;

   logic wr_count, wr_status, wr_epc;

   always_comb begin
      wr_count  = cp0_we && (cp0_waddr == CP0_REG_COUNT);
      wr_status = cp0_we && (cp0_waddr == CP0_REG_STATUS);
      wr_epc    = cp0_we && (cp0_waddr == CP0_REG_EPC);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count   <= '0;
         ie      <= 1'b0;
         exl     <= 1'b0;
         exccode <= '0;
         epc     <= '0;
      end else begin
         if (wr_count)
            count <= cp0_wdata;
         else
            count <= count + 32'd1;

         if (wr_status)
            ie <= cp0_wdata[STATUS_IE_BIT];

         // Exception entry/return override any concurrent Status.EXL write.
         if (exl_set)
            exl <= 1'b1;
         else if (exl_clr)
            exl <= 1'b0;
         else if (wr_status)
            exl <= cp0_wdata[STATUS_EXL_BIT];

         if (exccode_load)
            exccode <= exccode_value;

         if (epc_load)
            epc <= epc_value;
         else if (wr_epc)
            epc <= cp0_wdata;
      end
   end

   always_comb begin
      cp0_rdata = '0;
      case (cp0_raddr)
         CP0_REG_COUNT:  cp0_rdata = count;
         CP0_REG_STATUS: cp0_rdata = {30'b0, exl, ie};
         CP0_REG_CAUSE:  cp0_rdata = {25'b0, exccode, 2'b0};
         CP0_REG_EPC:    cp0_rdata = epc;
         default:        cp0_rdata = '0;
      endcase
   end

endmodule

// File: rtl/cp0_exc.sv
// CP0 exception responder: takes ALU overflow, raises a held redirect to the
// exception vector, and handles ERET by redirecting back to EPC.
module cp0_exc
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
   parameter logic [4:0]  EXC_OV     = EXC_CODE_OV
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ov_valid,
   input  logic [31:0] ov_pc,
   input  logic        eret,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic [4:0]  cp0_raddr,
   output logic [31:0] cp0_rdata,
   output logic        exc_req,
   output logic [31:0] exc_pc,
   input  logic        exc_ack,
   output logic [31:0] epc_out,
   output logic        exl
);

   cp0_state_t  state;
   logic [31:0] epc;

   logic take_exc, nested_exc, take_eret;

   // Overflow wins over a simultaneous ERET in HANDLER.
   always_comb begin
      take_exc   = (state == ST_RUN)     && ov_valid;
      nested_exc = (state == ST_HANDLER) && ov_valid;
      take_eret  = (state == ST_HANDLER) && eret && !ov_valid;
   end

   cp0_regs u_regs (
      .clk           (clk),
      .rst_n         (rst_n),
      .cp0_we        (cp0_we),
      .cp0_waddr     (cp0_waddr),
      .cp0_wdata     (cp0_wdata),
      .cp0_raddr     (cp0_raddr),
      .cp0_rdata     (cp0_rdata),
      .epc_load      (take_exc),
      .epc_value     (ov_pc),
      .exl_set       (take_exc),
      .exl_clr       (take_eret),
      .exccode_load  (take_exc || nested_exc),
      .exccode_value (EXC_OV),
      .epc           (epc),
      .exl           (exl)
   );

   assign epc_out = epc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_RUN;
         exc_req <= 1'b0;
         exc_pc  <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (ov_valid) begin
                  exc_req <= 1'b1;
                  exc_pc  <= EXC_VECTOR;
                  state   <= ST_EXC_PEND;
               end
            end
            ST_EXC_PEND: begin
               if (exc_ack) begin
                  exc_req <= 1'b0;
                  state   <= ST_HANDLER;
               end
            end
            ST_HANDLER: begin
               if (ov_valid) begin
                  exc_req <= 1'b1;
                  exc_pc  <= EXC_VECTOR;
                  state   <= ST_EXC_PEND;
               end else if (eret) begin
                  // Redirect uses EPC as held before this edge.
                  exc_req <= 1'b1;
                  exc_pc  <= epc;
                  state   <= ST_RET_PEND;
               end
            end
            ST_RET_PEND: begin
               if (exc_ack) begin
                  exc_req <= 1'b0;
                  state   <= ST_RUN;
               end
            end
            default: begin
               exc_req <= 1'b0;
               state   <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: doc/cp0_exc.md
Name: cp0_exc

Overview:
- Coprocessor-0 exception responder for the MIPS core; the consuming end of the ALU's arithmetic-overflow signal.
- Captures the faulting PC into EPC, records the cause, and raises a redirect request to the fetch stage, held until the pipeline acknowledges the flush.
- Handles ERET by redirecting back to EPC.
- Provides mtc0/mfc0 access to Count, Status, Cause and EPC.

Parameters:
- EXC_VECTOR, 32'h8000_0180: handler entry address driven on exc_pc when an exception is taken.
- EXC_OV, 5'd12: ExcCode written to Cause for arithmetic overflow.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- ov_valid  in  1  overflow from a valid EX-stage instruction (ALU overflow qualified by instruction valid)
- ov_pc  in  32  PC of the overflowing instruction
- eret  in  1  ERET executing, single-cycle pulse
- cp0_we  in  1  mtc0 write enable
- cp0_waddr  in  5  mtc0 register number
- cp0_wdata  in  32  mtc0 data
- cp0_raddr  in  5  mfc0 register number
- cp0_rdata  out  32  mfc0 data, combinational from current register contents (no write bypass)
- exc_req  out  1  redirect request to fetch and flush of younger instructions
- exc_pc  out  32  redirect target, valid while exc_req=1
- exc_ack  in  1  pipeline has flushed and taken the redirect
- epc_out  out  32  current EPC
- exl  out  1  Status.EXL

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state RUN, exc_req=0, exc_pc=0, EPC=0, Count=0, Status.EXL=0, Status.IE=0, Cause.ExcCode=0. Reset mid-handshake aborts it; exc_req drops on the next edge.
- Register map:
  - 9 = Count
  - 12 = Status {30'b0, EXL, IE}
  - 13 = Cause {25'b0, ExcCode[4:0], 2'b0}
  - 14 = EPC
  - any other address reads 0; writes to it are ignored.
- Writability:
  - Status: bits [1:0] writable.
  - EPC: all 32 bits writable.
  - Cause: read-only via mtc0.
  - Count: writable.
- Count: increments by 1 every cycle and wraps 32'hFFFF_FFFF->0. An mtc0 write loads cp0_wdata, and the write wins over the increment.
- State RUN:
  - ov_valid=1 takes the exception:
    - EPC<=ov_pc
    - ExcCode<=EXC_OV
    - EXL<=1
    - exc_req<=1
    - exc_pc<=EXC_VECTOR
    - next state EXC_PEND
  - eret in RUN has no effect.
- State EXC_PEND:
  - exc_req stays 1 and exc_pc is stable until exc_ack=1.
  - On the exc_ack cycle: exc_req<=0, next state HANDLER.
  - ov_valid and eret are ignored, since the pipeline is flushing.
- State HANDLER:
  - eret=1: EXL<=0, exc_req<=1, exc_pc<=EPC, next state RET_PEND.
  - ov_valid=1 (nested exception): EPC unchanged, ExcCode<=EXC_OV, exc_req<=1, exc_pc<=EXC_VECTOR, next state EXC_PEND.
  - ov_valid and eret in the same cycle: the overflow wins.
- State RET_PEND:
  - Hold exc_req until exc_ack; on ack go to RUN.
  - ov_valid is ignored.
- Latency: exc_req rises on the edge after ov_valid/eret, one cycle. Minimum handshake length is 1 cycle (exc_ack may already be high on the first cycle exc_req=1).
- Simultaneous exception entry and mtc0:
  - The exception's updates win for EPC and EXL.
  - A Status.IE write in the same cycle still takes effect.
  - A Count write still takes effect.
- ERET target is the EPC value registered at the eret edge. An mtc0 EPC write in the same cycle does not affect that redirect.
- exc_ack while exc_req=0: ignored.

Decomposition:
- Shared package cp0_pkg holds:
  - state encoding (RUN, EXC_PEND, HANDLER, RET_PEND)
  - CP0 register numbers (9/12/13/14)
  - Status bit positions
  - ExcCode constants
- Sub-module cp0_regs holds the register file, Count, and read mux.
- The FSM and redirect logic live in cp0_exc.

Test Plan:
- Reset then idle 10 cycles -> exc_req=0, mfc0 9 returns 10 (±1 per read cycle), mfc0 12/13/14 return 0.
- ov_valid=1, ov_pc=32'h0040_0010; exc_ack after 3 cycles:
  - exc_req=1 for 3 cycles with exc_pc=32'h8000_0180.
  - EPC=32'h0040_0010, Cause=32'h0000_0030, Status.EXL=1.
  - State reaches HANDLER.
- In HANDLER, eret; exc_ack 1 cycle later -> exc_req=1 with exc_pc=32'h0040_0010, EXL=0, state RUN.
- In HANDLER, ov_valid and eret same cycle with ov_pc=32'h0040_0100 -> exc_pc=32'h8000_0180, EPC still 32'h0040_0010, EXL=1.
- mtc0 Count=32'hFFFF_FFFE -> reads 32'hFFFF_FFFF then 32'h0000_0000. mtc0 Cause=32'hFFFF_FFFF -> Cause unchanged.
- Exception entry and mtc0 EPC=32'h1234_5678 same cycle -> EPC=ov_pc. rst_n=0 during EXC_PEND -> next edge exc_req=0, all registers 0.
